// File: rtl/assoc_cache.sv
// assoc_cache -- N-way set-associative, write-back, write-allocate cache.
// It sits between the LC-3b datapath (16-bit word port) and physical memory
// (128-bit line port).
//
// Optional feature macro: ASSOC_CACHE_PERF_CNT_EN
//   When defined, the hit_count and miss_count ports and their counters exist.
//
// Parameters
//   WAYS : associativity, a power of two from 1 to 8
//   SETS : sets per way, a power of two from 2 to 64
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   mem_address         byte address: [3:0] offset, then index, then tag
//   mem_wdata           write data
//   mem_read            read request, held until mem_resp
//   mem_write           write request, held until mem_resp
//   mem_byte_enable     byte lanes for writes
//   mem_rdata           read data, valid with mem_resp
//   mem_resp            one-cycle completion
//   pmem_address        line-aligned physical address
//   pmem_wdata          victim line being written back
//   pmem_read           line fill request
//   pmem_write          line writeback request
//   pmem_rdata          fill data
//   pmem_resp           physical memory completion
//   hit_count           (optional) requests served without a miss
//   miss_count          (optional) misses started
module assoc_cache #(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef ASSOC_CACHE_PERF_CNT_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 12 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FILL
  } state_t;

  state_t state_q, state_d;

  // Line storage, one entry per way and set
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [127:0]      data_q  [WAYS][SETS];
  logic [WAY_W-1:0]  age_q   [WAYS][SETS];

  // Miss context, captured when leaving IDLE so the line transfer completes
  // even if the requester drops its request mid-transfer.
  logic [WAY_W-1:0]  miss_way_q;
  logic [IDX_W-1:0]  miss_idx_q;
  logic [TAG_W-1:0]  miss_tag_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [2:0]        word_sel;
  logic              req;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  hit_age;
  logic [WAY_W-1:0]  vict_way;
  logic              found_inv;
  logic              vict_dirty;
  logic [127:0]      hit_line;
  logic [127:0]      merged_line;
  logic              hit_upd;
  logic              miss_start;
  logic              fill_done;
  logic              unused_addr_bit;

  function automatic logic [127:0] merge_line(input logic [127:0] line,
                                              input logic [2:0]   sel,
                                              input logic [15:0]  wd,
                                              input logic [1:0]   be);
    logic [127:0] res;
    res = line;
    if (be[0]) res[{sel, 4'h0} +: 8] = wd[7:0];
    if (be[1]) res[{sel, 4'h8} +: 8] = wd[15:8];
    return res;
  endfunction

  assign req_idx         = mem_address[4 +: IDX_W];
  assign req_tag         = mem_address[15 -: TAG_W];
  assign word_sel        = mem_address[3:1];
  assign req             = mem_read | mem_write;
  assign unused_addr_bit = mem_address[0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: first invalid way, else the way holding the oldest age.
  // Ages in a set are a permutation of 0..WAYS-1, so the oldest is WAYS-1.
  always_comb begin
    vict_way  = '0;
    found_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[w][req_idx]) begin
        found_inv = 1'b1;
        vict_way  = WAY_W'(w);
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w][req_idx] == WAY_W'(WAYS - 1)) vict_way = WAY_W'(w);
      end
    end
  end

  assign vict_dirty  = valid_q[vict_way][req_idx] & dirty_q[vict_way][req_idx];
  assign hit_line    = data_q[hit_way][req_idx];
  assign hit_age     = age_q[hit_way][req_idx];
  assign merged_line = merge_line(hit_line, word_sel, mem_wdata, mem_byte_enable);

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    hit_upd      = 1'b0;
    miss_start   = 1'b0;
    fill_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            hit_upd  = 1'b1;
            if (!mem_write) mem_rdata = hit_line[{word_sel, 4'h0} +: 16];
          end else begin
            miss_start = 1'b1;
            state_d    = vict_dirty ? S_WRITEBACK : S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[miss_way_q][miss_idx_q], miss_idx_q, 4'b0000};
        pmem_wdata   = data_q[miss_way_q][miss_idx_q];
        if (pmem_resp) state_d = S_FILL;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag_q, miss_idx_q, 4'b0000};
        if (pmem_resp) begin
          fill_done = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (miss_start) begin
      miss_way_q <= vict_way;
      miss_idx_q <= req_idx;
      miss_tag_q <= req_tag;
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    localparam logic [WAY_W-1:0] WAY_ID = WAY_W'(g);
    logic fill_me;
    logic hit_me;

    assign fill_me = fill_done && (miss_way_q == WAY_ID);
    assign hit_me  = hit_upd && (hit_way == WAY_ID);

    // Hitting way becomes youngest; every way younger than it ages by one.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q[g] <= '0;
        dirty_q[g] <= '0;
        age_q[g]   <= '{default: WAY_ID};
      end else begin
        if (fill_me) begin
          valid_q[g][miss_idx_q] <= 1'b1;
          dirty_q[g][miss_idx_q] <= 1'b0;
        end
        if (hit_me && mem_write) dirty_q[g][req_idx] <= 1'b1;
        if (hit_me) begin
          age_q[g][req_idx] <= '0;
        end else if (hit_upd && (age_q[g][req_idx] < hit_age)) begin
          age_q[g][req_idx] <= age_q[g][req_idx] + 1'b1;
        end
      end
    end

    // Tags and line data are never cleared by reset.
    always_ff @(posedge clk) begin
      if (rst_n && fill_me) begin
        tag_q[g][miss_idx_q]  <= miss_tag_q;
        data_q[g][miss_idx_q] <= pmem_rdata;
      end else if (rst_n && hit_me && mem_write) begin
        data_q[g][req_idx] <= merged_line;
      end
    end
  end

`ifdef ASSOC_CACHE_PERF_CNT_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;
  logic        missed_q;

  // missed_q marks a request whose final mem_resp follows its own fill and
  // therefore must not be counted as a hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      missed_q   <= 1'b0;
    end else begin
      if (miss_start) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
        missed_q   <= 1'b1;
      end else if (mem_resp) begin
        if (!missed_q) hit_cnt_q <= hit_cnt_q + 16'd1;
        missed_q <= 1'b0;
      end else if ((state_q == S_IDLE) && !req) begin
        missed_q <= 1'b0;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
